// File: rtl/fft_pipe_ctrl.sv
// Sequencing controller for the 4-lane radix-2^2 FFT pipeline: coefficient ROM and BFII timing,
// output qualifiers, and (when FFT_CTRL_FLUSH_EN is defined) a zero-fill drain of the pipeline.
module fft_pipe_ctrl #(
  parameter int unsigned N_CYC = 32,
  parameter int unsigned D     = 16,
  parameter int unsigned AW    = 5,
  parameter int unsigned FW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic          advance,
  output logic          flush_active,
  output logic          coeff_en0,
  output logic [AW-1:0] coeff_addr0,
  output logic          coeff_en1,
  output logic [AW-1:0] coeff_addr1,
  output logic          bf2_ctrl,
  output logic          out_valid,
  output logic          out_sof,
  output logic          out_eof,
  output logic [FW-1:0] frame_cnt,
  output logic          busy
);

  localparam int unsigned   DW     = $clog2(D);
  localparam logic [AW-1:0] S_LAST = AW'(N_CYC - 1);
  localparam logic [DW-1:0] D_LAST = DW'(D - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] s_q, s_d;
  logic [AW-1:0] s2_q, s2_d;
  logic [DW-1:0] fill_cnt_q, fill_cnt_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          stage2_c;

`ifdef FFT_CTRL_FLUSH_EN
  logic          flush_pend_q, flush_pend_d;
  logic [DW-1:0] flush_cnt_q, flush_cnt_d;
`else
  logic          unused_flush;
  assign unused_flush = flush;
`endif

  // State and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      s_q        <= '0;
      s2_q       <= '0;
      fill_cnt_q <= '0;
      frame_q    <= '0;
`ifdef FFT_CTRL_FLUSH_EN
      flush_pend_q <= 1'b0;
      flush_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      s2_q       <= s2_d;
      fill_cnt_q <= fill_cnt_d;
      frame_q    <= frame_d;
`ifdef FFT_CTRL_FLUSH_EN
      flush_pend_q <= flush_pend_d;
      flush_cnt_q  <= flush_cnt_d;
`endif
    end
  end

  // Next state; the flush drain starts on the frame boundary so the last input frame completes
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    s2_d       = s2_q;
    fill_cnt_d = fill_cnt_q;
    frame_d    = frame_q;
`ifdef FFT_CTRL_FLUSH_EN
    flush_pend_d = flush_pend_q;
    flush_cnt_d  = flush_cnt_q;
    if (flush && (state_q == ST_FILL || state_q == ST_RUN)) begin
      flush_pend_d = 1'b1;
    end
`endif
    if (advance) begin
      s_d = s_q + AW'(1);
      if (stage2_c) begin
        s2_d = s2_q + AW'(1);
      end
      if (out_eof) begin
        frame_d = frame_q + FW'(1);
      end
      unique case (state_q)
        ST_IDLE: begin
          state_d    = ST_FILL;
          fill_cnt_d = fill_cnt_q + DW'(1);
        end
        ST_FILL: begin
          fill_cnt_d = fill_cnt_q + DW'(1);
          if (fill_cnt_q == D_LAST) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
`ifdef FFT_CTRL_FLUSH_EN
          if (s_q == S_LAST && (flush_pend_q || flush)) begin
            state_d      = ST_FLUSH;
            flush_pend_d = 1'b0;
          end
`endif
        end
        ST_FLUSH: begin
`ifdef FFT_CTRL_FLUSH_EN
          flush_cnt_d = flush_cnt_q + DW'(1);
          if (flush_cnt_q == D_LAST) begin
            state_d     = ST_IDLE;
            s_d         = '0;
            s2_d        = '0;
            fill_cnt_d  = '0;
            flush_cnt_d = '0;
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs: combinational from registered state and the current enable/in_valid
  always_comb begin
    in_ready     = enable;
    flush_active = 1'b0;
`ifdef FFT_CTRL_FLUSH_EN
    in_ready     = enable & (state_q != ST_FLUSH);
    flush_active = enable & (state_q == ST_FLUSH);
`endif
    advance     = (in_valid & in_ready) | flush_active;
    stage2_c    = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    coeff_en0   = advance;
    coeff_addr0 = s_q;
    coeff_en1   = advance & stage2_c;
    coeff_addr1 = s2_q;
    bf2_ctrl    = s2_q[DW];
    out_valid   = coeff_en1;
    out_sof     = coeff_en1 & (s2_q == '0);
    out_eof     = coeff_en1 & (s2_q == S_LAST);
    frame_cnt   = frame_q;
    busy        = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_fft_pipe_ctrl.sv
// Bench for fft_pipe_ctrl: frame-level model compared every cycle plus literal expectations
// for latency, frame counts, stall and flush behaviour (flush checks follow FFT_CTRL_FLUSH_EN).
module tb_fft_pipe_ctrl;

  localparam int unsigned N_CYC = 32;
  localparam int unsigned D     = 16;
  localparam int unsigned AW    = 5;
  localparam int unsigned FW    = 8;
`ifdef FFT_CTRL_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic          clk, rst, enable, in_valid, flush;
  logic          in_ready, advance, flush_active, coeff_en0, coeff_en1;
  logic          bf2_ctrl, out_valid, out_sof, out_eof, busy;
  logic [AW-1:0] coeff_addr0, coeff_addr1;
  logic [FW-1:0] frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  fft_pipe_ctrl #(.N_CYC(N_CYC), .D(D), .AW(AW), .FW(FW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .advance(advance), .flush_active(flush_active),
    .coeff_en0(coeff_en0), .coeff_addr0(coeff_addr0),
    .coeff_en1(coeff_en1), .coeff_addr1(coeff_addr1), .bf2_ctrl(bf2_ctrl),
    .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: m_k = advances accepted since the pipeline last left IDLE
  int m_k, m_left, m_frames;
  bit m_fl, m_pend;
  int adv_cnt, first_sof, first_eof, valid_cnt, bf2_toggles;
  bit last_bf2;

  always @(negedge clk) begin
    int s, s2;
    bit live, fill, run, e_ready, e_adv, e_en1, e_sof, e_eof, trig;
    if (!rst) begin
      m_k = 0; m_left = 0; m_frames = 0; m_fl = 0; m_pend = 0;
      adv_cnt = 0; first_sof = -1; first_eof = -1; valid_cnt = 0; bf2_toggles = 0; last_bf2 = 0;
    end
    live    = (m_k >= int'(D));
    fill    = (m_k > 0) && !live;
    run     = live && !m_fl;
    s       = m_k % int'(N_CYC);
    s2      = live ? (m_k - int'(D)) % int'(N_CYC) : 0;
    e_ready = enable && !m_fl;
    e_adv   = (in_valid && e_ready) || (m_fl && enable);
    e_en1   = e_adv && live;
    e_sof   = e_en1 && (s2 == 0);
    e_eof   = e_en1 && (s2 == int'(N_CYC) - 1);

    chk("in_ready",     int'(in_ready),     int'(e_ready));
    chk("advance",      int'(advance),      int'(e_adv));
    chk("flush_active", int'(flush_active), int'(m_fl && enable));
    chk("coeff_en0",    int'(coeff_en0),    int'(e_adv));
    chk("coeff_addr0",  int'(coeff_addr0),  s);
    chk("coeff_en1",    int'(coeff_en1),    int'(e_en1));
    chk("coeff_addr1",  int'(coeff_addr1),  s2);
    chk("bf2_ctrl",     int'(bf2_ctrl),     (s2 / int'(D)) % 2);
    chk("out_valid",    int'(out_valid),    int'(e_en1));
    chk("out_sof",      int'(out_sof),      int'(e_sof));
    chk("out_eof",      int'(out_eof),      int'(e_eof));
    chk("frame_cnt",    int'(frame_cnt),    m_frames % (1 << FW));
    chk("busy",         int'(busy),         int'((m_k != 0) || m_fl));

    // Observed-event bookkeeping for the literal checks in the stimulus
    if (advance) adv_cnt++;
    if (out_sof && first_sof < 0) first_sof = adv_cnt;
    if (out_eof && first_eof < 0) first_eof = adv_cnt;
    if (out_valid) begin
      valid_cnt++;
      if (valid_cnt > 1 && bf2_ctrl != last_bf2) bf2_toggles++;
      last_bf2 = bf2_ctrl;
    end

    if (rst) begin
      trig = FLUSH_EN && run && e_adv && (s == int'(N_CYC) - 1) && (m_pend || flush);
      if (FLUSH_EN && flush && (fill || run)) m_pend = 1;
      if (e_adv) begin
        if (e_eof) m_frames++;
        m_k++;
        if (m_fl) begin
          m_left--;
          if (m_left == 0) begin
            m_fl = 0;
            m_k  = 0;
          end
        end else if (trig) begin
          m_fl   = 1;
          m_left = int'(D);
          m_pend = 0;
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic en, input logic fl);
    @(posedge clk); #1;
    in_valid = v;
    enable   = en;
    flush    = fl;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    enable   = 1'b1;
    #1 rst = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fa;
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; flush = 1'b0;
    #1 rst = 1'b0;
    #1 chk("rst_in_ready_en0", int'(in_ready), 0);
    enable = 1'b1;
    #1 chk("rst_in_ready_en1", int'(in_ready), 1);
    chk("rst_busy",      int'(busy),        0);
    chk("rst_out_valid", int'(out_valid),   0);
    chk("rst_advance",   int'(advance),     0);
    chk("rst_frame_cnt", int'(frame_cnt),   0);
    chk("rst_addr1",     int'(coeff_addr1), 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;

    // Continuous input: latency, first frame, then four back-to-back frames
    repeat (48) cyc(1, 1, 0);
    cyc(1, 1, 0);
    @(negedge clk); #1;
    chk("first_sof_adv", first_sof, 17);
    chk("first_eof_adv", first_eof, 48);
    chk("frame_cnt_1",   int'(frame_cnt), 1);
    repeat (95) cyc(1, 1, 0);
    cyc(0, 1, 0);
    @(negedge clk); #1;
    chk("frame_cnt_4",     int'(frame_cnt), 4);
    chk("valid_cnt_4fr",   valid_cnt, 128);
    chk("bf2_toggles_4fr", bf2_toggles, 7);

    // Alternating in_valid
    do_reset();
    repeat (60) begin
      cyc(1, 1, 0);
      cyc(0, 1, 0);
    end
    @(negedge clk); #1;
    chk("alt_first_sof_adv", first_sof, 17);
    chk("alt_first_eof_adv", first_eof, 48);
    chk("alt_frame_cnt",     int'(frame_cnt), 1);
    chk("alt_valid_cnt",     valid_cnt, 44);

    // Enable low for 5 cycles with s2 = 10
    do_reset();
    repeat (26) cyc(1, 1, 0);
    repeat (5) begin
      cyc(1, 0, 0);
      @(negedge clk); #1;
      chk("stall_valid",   int'(out_valid),   0);
      chk("stall_advance", int'(advance),     0);
      chk("stall_addr1",   int'(coeff_addr1), 10);
    end
    cyc(1, 1, 0);
    @(negedge clk); #1;
    chk("resume_addr1", int'(coeff_addr1), 10);
    chk("resume_valid", int'(out_valid),   1);
    repeat (10) cyc(1, 1, 0);

    // Flush requested at s = 7 in RUN (advance 40)
    do_reset();
    repeat (39) cyc(1, 1, 0);
    cyc(1, 1, 1);
    repeat (24) cyc(1, 1, 0);
    fa = 0;
    repeat (20) begin
      cyc(0, 1, 0);
      @(negedge clk); #1;
      if (flush_active) fa++;
    end
    chk("flush_cycles",     fa, FLUSH_EN ? 16 : 0);
    chk("flush_busy_after", int'(busy), FLUSH_EN ? 0 : 1);
    chk("flush_frame_cnt",  int'(frame_cnt), FLUSH_EN ? 2 : 1);

    // Reset pulsed in the middle of the drain
    do_reset();
    repeat (39) cyc(1, 1, 0);
    cyc(1, 1, 1);
    repeat (24) cyc(1, 1, 0);
    repeat (5) cyc(0, 1, 0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy",      int'(busy),         0);
    chk("midrst_flush_act", int'(flush_active), 0);
    chk("midrst_valid",     int'(out_valid),    0);
    chk("midrst_addr1",     int'(coeff_addr1),  0);
    chk("midrst_frame_cnt", int'(frame_cnt),    0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (20) cyc(1, 1, 0);
    cyc(0, 1, 0);
    @(negedge clk); #1;
    chk("restart_first_sof_adv", first_sof, 17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
